// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_SHR1 = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial-product add per step.
module mul_shift_add #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // prod is the accumulator after the current step, so the final step's
  // sum can be written out on the same edge that performs it.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod     = acc_q + (mplier_q[0] ? mcand_q : '0);
    last     = (cnt_q == CW'(WIDTH - 1));
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = prod;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake; single-cycle logic/arith ops
// and a WIDTH-cycle multiply delegated to mul_shift_add.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 carry
);

  // Returns {carry, low result} for every opcode except MUL.
  function automatic logic [WIDTH:0] alu_single(input logic [2:0]       f_op,
                                                input logic [WIDTH-1:0] f_a,
                                                input logic [WIDTH-1:0] f_b);
    logic [WIDTH:0] r;
    case (f_op)
      OP_ADD:  r = {1'b0, f_a} + {1'b0, f_b};
      OP_SUB:  r = {1'b0, f_a} - {1'b0, f_b};
      OP_AND:  r = {1'b0, f_a & f_b};
      OP_OR:   r = {1'b0, f_a | f_b};
      OP_XOR:  r = {1'b0, f_a ^ f_b};
      OP_SHL1: r = {f_a[WIDTH-1], f_a[WIDTH-2:0], 1'b0};
      OP_SHR1: r = {f_a[0], 1'b0, f_a[WIDTH-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t               state_q, state_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH:0]       single_res;

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mul_load),
    .step  (mul_step),
    .a     (a),
    .b     (b),
    .last  (mul_last),
    .prod  (mul_prod)
  );

  assign single_res = alu_single(op, a, b);

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            result_d = {{WIDTH{1'b0}}, single_res[WIDTH-1:0]};
            carry_d  = single_res[WIDTH];
            zero_d   = (single_res[WIDTH-1:0] == '0);
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          result_d = mul_prod;
          carry_d  = (mul_prod[2*WIDTH-1:WIDTH] != '0);
          zero_d   = (mul_prod == '0);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign busy   = (state_q == ST_MUL);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=4.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = 3'b000;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, zero, carry;
  logic [2*WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero),
    .carry  (carry)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] o, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if ({result, zero, carry} !== 10'h000) begin errors++; $display("FAIL reset_outputs got %h/%b/%b want 00/0/0", result, zero, carry); end
    @(negedge clk);
    rst_n = 1'b1;
    // give result a non-zero value so the mid-multiply reset is visible
    drive(OP_ADD, 4'd2, 4'd3);
    edge1();
    start = 1'b0;
    checks++; if (result !== 8'h05) begin errors++; $display("FAIL pre_add got %h want 05", result); end
    drive(OP_MUL, 4'd7, 4'd5);
    edge1();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy got %b want 1", busy); end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_reset_ctrl got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL async_reset_result got %h want 00", result); end
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dcount = 0;
      for (int i = 0; i < 8; i++) begin
        edge1();
        if (done === 1'b1) dcount++;
      end
      checks++; if (dcount !== 0) begin errors++; $display("FAIL no_done_after_reset got %0d pulses want 0", dcount); end
    end
  endtask

  task automatic test_add_sub();
    drive(OP_ADD, 4'd9, 4'd8);
    edge1();
    start = 1'b0;
    checks++; if ({done, result, carry, zero} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_9_8 got done=%b res=%h c=%b z=%b want 1/01/1/0", done, result, carry, zero);
    end
    edge1();
    checks++; if (done !== 1'b0 || result !== 8'h01) begin errors++; $display("FAIL add_hold got done=%b res=%h want 0/01", done, result); end
    drive(OP_SUB, 4'd3, 4'd5);
    edge1();
    start = 1'b0;
    checks++; if ({done, result, carry, zero} !== {1'b1, 8'h0E, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_3_5 got done=%b res=%h c=%b z=%b want 1/0E/1/0", done, result, carry, zero);
    end
  endtask

  task automatic test_mul();
    logic [WIDTH-1:0]   va [2] = '{4'd15, 4'd6};
    logic [WIDTH-1:0]   vb [2] = '{4'd15, 4'd0};
    logic [2*WIDTH-1:0] er [2] = '{8'hE1, 8'h00};
    logic               ec [2] = '{1'b1, 1'b0};
    logic               ez [2] = '{1'b0, 1'b1};
    for (int v = 0; v < 2; v++) begin
      drive(OP_MUL, va[v], vb[v]);
      edge1();
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
          errors++; $display("FAIL mul%0d_busy_cycle%0d got busy=%b done=%b want 1/0", v, c, busy, done);
        end
        if (c < 3) edge1();
      end
      edge1();
      checks++; if ({done, busy, result, carry, zero} !== {1'b1, 1'b0, er[v], ec[v], ez[v]}) begin
        errors++; $display("FAIL mul%0d_result got done=%b busy=%b res=%h c=%b z=%b want 1/0/%h/%b/%b",
                           v, done, busy, result, carry, zero, er[v], ec[v], ez[v]);
      end
      edge1();
      checks++; if (done !== 1'b0 || result !== er[v]) begin errors++; $display("FAIL mul%0d_after got done=%b res=%h want 0/%h", v, done, result, er[v]); end
    end
  endtask

  task automatic test_busy_ignore();
    int dcount = 0;
    int dedge = -1;
    drive(OP_MUL, 4'd3, 4'd4);
    edge1();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 4'd1; b = 4'd1;
    @(negedge clk);
    start = 1'b0;
    // edge index counted from the accepting edge N; one edge already passed plus the one at the negedge above
    for (int i = 2; i < 10; i++) begin
      edge1();
      if (done === 1'b1) begin
        dcount++;
        if (dedge < 0) dedge = i;
        checks++; if (result !== 8'h0C) begin errors++; $display("FAIL busy_ignore_result got %h want 0C", result); end
      end
    end
    checks++; if (dcount !== 1) begin errors++; $display("FAIL busy_ignore_done_count got %0d want 1", dcount); end
    checks++; if (dedge !== 4) begin errors++; $display("FAIL busy_ignore_done_edge got %0d want 4", dedge); end
  endtask

  task automatic test_back_to_back();
    drive(OP_XOR, 4'hA, 4'hA);
    edge1();
    checks++; if ({done, result, zero} !== {1'b1, 8'h00, 1'b1}) begin
      errors++; $display("FAIL b2b_xor got done=%b res=%h z=%b want 1/00/1", done, result, zero);
    end
    op = OP_SHL1; a = 4'h9; b = 4'h0;
    edge1();
    start = 1'b0;
    checks++; if ({done, result, carry, zero} !== {1'b1, 8'h02, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_shl1 got done=%b res=%h c=%b z=%b want 1/02/1/0", done, result, carry, zero);
    end
    edge1();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got %b want 0", done); end
  endtask

  task automatic test_shr_and();
    drive(OP_SHR1, 4'h1, 4'h0);
    edge1();
    start = 1'b0;
    checks++; if ({done, result, zero, carry} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL shr1_1 got done=%b res=%h z=%b c=%b want 1/00/1/1", done, result, zero, carry);
    end
    drive(OP_AND, 4'hC, 4'h6);
    edge1();
    start = 1'b0;
    checks++; if ({done, result, zero, carry} !== {1'b1, 8'h04, 1'b0, 1'b0}) begin
      errors++; $display("FAIL and_c_6 got done=%b res=%h z=%b c=%b want 1/04/0/0", done, result, zero, carry);
    end
    drive(OP_OR, 4'h5, 4'h8);
    edge1();
    start = 1'b0;
    checks++; if ({result, carry} !== {8'h0D, 1'b0}) begin errors++; $display("FAIL or_5_8 got res=%h c=%b want 0D/0", result, carry); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_busy_ignore();
    test_back_to_back();
    test_shr_and();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
